// File: rtl/gate_pkg.sv
// Shared definitions for the gate array unit: operation encodings and widths.
package gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

endpackage

// File: rtl/gate_op.sv
// Combinational bitwise gate: applies one of eight logic operations across WIDTH bits.
module gate_op
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OP_AND:    f = a & b;
            OP_OR:     f = a | b;
            OP_XOR:    f = a ^ b;
            OP_NAND:   f = ~(a & b);
            OP_NOR:    f = ~(a | b);
            OP_XNOR:   f = ~(a ^ b);
            OP_NOT_A:  f = ~a;
            OP_PASS_A: f = a;
        endcase
    end

endmodule

// File: rtl/gate_array_unit.sv
// Registered gate unit with a one-entry valid/ready output buffer and a saturating drain counter.
// Define GATE_ARRAY_UNIT_PARITY_EN to add the registered parity output par.
module gate_array_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef GATE_ARRAY_UNIT_PARITY_EN
    output logic             par,
`endif
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] f;
    logic             accept, drain;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] count_q, count_d;
`ifdef GATE_ARRAY_UNIT_PARITY_EN
    logic             par_q, par_d;
`endif

    gate_op #(.WIDTH(WIDTH)) u_gate_op (
        .a  (a),
        .b  (b),
        .op (op_t'(op)),
        .f  (f)
    );

    // A drain in the same cycle frees the slot, so accepts never bubble.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        zero_d  = zero_q;
        count_d = count_q;
`ifdef GATE_ARRAY_UNIT_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            valid_d = 1'b1;
            y_d     = f;
            zero_d  = (f == '0);
`ifdef GATE_ARRAY_UNIT_PARITY_EN
            par_d   = ^f;
`endif
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (drain && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            count_q <= '0;
`ifdef GATE_ARRAY_UNIT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            count_q <= count_d;
`ifdef GATE_ARRAY_UNIT_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign count     = count_q;
`ifdef GATE_ARRAY_UNIT_PARITY_EN
    assign par       = par_q;
`endif

endmodule
